// File: rtl/ofm_fifo_pkg.sv
// ofm_fifo_pkg: shared width helpers and per-lane status struct for the multi-channel OFM FIFO.
//   cnt_w(depth)       : occupancy counter width, holds 0..depth
//   ptr_w(depth)       : RAM pointer width, addresses 0..depth-1
//   ofm_fifo_status_t  : per-lane flag bundle returned by each lane
package ofm_fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } ofm_fifo_status_t;

endpackage

// File: rtl/ofm_fifo_if.sv
// ofm_fifo_if: per-lane handshake, data and status bundle of the multi-channel OFM FIFO.
//   master : PE-array / write-back side (drives clr, wr_en, data_in, rd_en)
//   slave  : FIFO side (drives data_out, rd_valid, count and all status flags)
//   Lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH] of data_in/data_out and [i*CNT_W +: CNT_W] of count.
interface ofm_fifo_if
    import ofm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4608,
    parameter int NUM_CH     = 4
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [NUM_CH-1:0]            clr;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]            rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out;
    logic [NUM_CH-1:0]            rd_valid;
    logic [NUM_CH-1:0]            empty;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            almost_empty;
    logic [NUM_CH-1:0]            almost_full;
    logic [NUM_CH*CNT_W-1:0]      count;
    logic [NUM_CH-1:0]            overflow;
    logic [NUM_CH-1:0]            underflow;

    modport master (
        output clr, wr_en, data_in, rd_en,
        input  data_out, rd_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output data_out, rd_valid, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/ofm_fifo_lane.sv
// ofm_fifo_lane: one independent FIFO lane (RAM, wrapping pointers, exact count, flags, sticky errors).
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   i_clr      : synchronous lane clear, wins over i_wr_en/i_rd_en
//   i_wr_en    : write request, accepted only when not full
//   i_data     : write data
//   i_rd_en    : read request (pop acknowledge in FWFT mode), accepted only when not empty
//   o_data     : read data, o_rd_valid qualifies it
//   o_count    : occupancy 0..DEPTH
//   o_status   : empty/full/almost flags and sticky overflow/underflow
//   OFM_FIFO_FWFT_EN: when defined, head word is presented combinationally and o_rd_valid = !empty.
module ofm_fifo_lane
    import ofm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4608,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_wr_en,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_rd_en,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_rd_valid,
    output logic [cnt_w(DEPTH)-1:0]     o_count,
    output ofm_fifo_status_t            o_status
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf, r_udf;
    logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

    assign w_full   = r_count == CNT_W'(DEPTH);
    assign w_empty  = r_count == '0;
    // acceptance uses this cycle's flags only, so a simultaneous pop never frees room for a push at full
    assign w_wr_acc = i_wr_en && !w_full && !i_clr;
    assign w_rd_acc = i_rd_en && !w_empty && !i_clr;

    always_ff @(posedge clk)
        if (w_wr_acc && !rst) r_mem[r_wr_ptr] <= i_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            // explicit wrap keeps non-power-of-two depths inside the RAM
            if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
            r_ovf   <= r_ovf || (i_wr_en && w_full);
            r_udf   <= r_udf || (i_rd_en && w_empty);
        end
    end

`ifdef OFM_FIFO_FWFT_EN
    assign o_data     = r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rd_valid;

    // clr drops rd_valid but deliberately leaves the last word on r_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
        end
    end

    assign o_data     = r_data;
    assign o_rd_valid = r_rd_valid;
`endif

    assign o_count  = r_count;
    assign o_status = '{
        empty:        w_empty,
        full:         w_full,
        almost_empty: r_count <= CNT_W'(AE_THRESH),
        almost_full:  r_count >= CNT_W'(AF_THRESH),
        overflow:     r_ovf,
        underflow:    r_udf
    };

endmodule

// File: rtl/ofm_fifo_mc.sv
// ofm_fifo_mc: NUM_CH independent OFM FIFO lanes between the PE array and OFM write-back.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : ofm_fifo_if slave modport carrying all per-lane handshake, data, count and status vectors
//   OFM_FIFO_FWFT_EN: when defined, every lane runs in first-word-fall-through mode.
module ofm_fifo_mc
    import ofm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4608,
    parameter int NUM_CH     = 4,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic      clk,
    input  logic      rst,
    ofm_fifo_if.slave bus
);
    localparam int CNT_W = cnt_w(DEPTH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        ofm_fifo_status_t w_status;

        ofm_fifo_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_THRESH  (AF_THRESH),
            .AE_THRESH  (AE_THRESH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_clr      (bus.clr[g]),
            .i_wr_en    (bus.wr_en[g]),
            .i_data     (bus.data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_rd_en    (bus.rd_en[g]),
            .o_data     (bus.data_out[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_rd_valid (bus.rd_valid[g]),
            .o_count    (bus.count[g*CNT_W +: CNT_W]),
            .o_status   (w_status)
        );

        assign bus.empty[g]        = w_status.empty;
        assign bus.full[g]         = w_status.full;
        assign bus.almost_empty[g] = w_status.almost_empty;
        assign bus.almost_full[g]  = w_status.almost_full;
        assign bus.overflow[g]     = w_status.overflow;
        assign bus.underflow[g]    = w_status.underflow;
    end

endmodule

// File: doc/ofm_fifo_mc.md
# ofm_fifo_mc

Parametrised multi-channel output-feature-map FIFO: NUM_CH independent lanes, each buffering convolution results between the PE array and the OFM write-back path. Each lane has its own write/read handshake, occupancy count, exact full/empty, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It replaces the single-lane OFM FIFO with a correct full-depth count and a unified per-lane clear.

## Interface
- DATA_WIDTH, 16, bits per word
- DEPTH, 4608, words per lane; any value >= 2, power of two not required
- NUM_CH, 4, number of independent lanes
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  NUM_CH  synchronous per-lane clear
- wr_en  in  NUM_CH  per-lane write request
- data_in  in  NUM_CH*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- rd_en  in  NUM_CH  per-lane read request
- data_out  out  NUM_CH*DATA_WIDTH  per-lane read data, same packing
- rd_valid  out  NUM_CH  per-lane data_out qualifier
- empty, full, almost_empty, almost_full  out  NUM_CH each  per-lane status
- count  out  NUM_CH*CNT_W  per-lane occupancy, CNT_W = $clog2(DEPTH+1)
- overflow, underflow  out  NUM_CH each  sticky error flags

## Operation
- Lanes are fully independent; description below is per lane.
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Acceptance evaluates against the current-cycle flags only. A read in the same cycle does not free space for a write at full, and a write does not make a read valid at empty.
- Write stores data_in at wr_ptr. Pointers are PTR_W = $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 explicitly; a non-power-of-two DEPTH never addresses beyond DEPTH-1.
- count_next = count + write_acc - read_acc; range 0..DEPTH, never wraps.
- Flags decode from the registered count: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_THRESH), almost_empty = (count <= AE_THRESH).
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both are sticky until clr or rst.
- clr has priority over wr_en/rd_en in the same cycle; both are discarded. clr zeroes the pointers, count, rd_valid, overflow and underflow. data_out holds its value. RAM contents are not cleared.
- rst (asynchronous, any time, including mid-burst): pointers, count, data_out, rd_valid, overflow and underflow all go to 0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).

## Timing
- Write at edge N: count, empty and the almost flags reflect it from cycle N+1. A read may be accepted in cycle N+1.
- Default (registered read): read accepted at edge N -> data_out = mem[rd_ptr] and rd_valid=1 during cycle N+1. rd_valid is 0 in any cycle not following an accepted read. data_out holds the last value when no read is accepted.
- Back-to-back reads sustain 1 word/cycle. Simultaneous write and read at 0 < count < DEPTH leaves count unchanged.

## Configuration
- OFM_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as a pop acknowledge; read latency 0.
  - Word written at edge N appears on data_out in cycle N+1.
- OFM_FIFO_FWFT_EN undefined: registered-read behaviour as in Timing.

## Structure
- Package ofm_fifo_pkg: function cnt_w(depth) returning $clog2(depth+1), function ptr_w(depth), and typedef ofm_fifo_status_t (packed struct: empty, full, almost_empty, almost_full, overflow, underflow).
- Sub-module ofm_fifo_lane: one lane (RAM, pointers, count, flags, error flags, FWFT option). The top generates NUM_CH instances and packs/unpacks the vectors.

## Test plan
- Fill/drain lane 0, DEPTH=8: 8 writes of 0x0001..0x0008 -> full=1, count=8, almost_full from count 4 (AF_THRESH=4). 8 reads -> data_out 0x0001..0x0008 in order, empty=1.
- Wrap-around, DEPTH=6: 4 writes, 4 reads, then 6 writes 0xA0..0xA5 -> full=1, count=6. Reads return 0xA0..0xA5 across the pointer wrap.
- Boundary collisions: at count=8 (full) wr_en+rd_en -> read accepted, write rejected, count=7, overflow=1. At count=0 wr_en+rd_en -> write accepted, rd_valid=0, count=1, underflow=1.
- Lane independence and clr: write 3 words to lanes 0 and 2, pulse clr[2] with wr_en[2]=1 -> lane 2 count=0, empty=1, flags cleared. Lane 0 count=3 and its data are intact.
- Async reset mid-burst: rst asserted between edges during simultaneous writes and reads on all lanes -> all counts 0, empty=1 immediately, no spurious rd_valid after release.
- Both builds: with OFM_FIFO_FWFT_EN, a write of 0x1234 at edge N gives data_out=0x1234 and rd_valid=1 in cycle N+1. Without it, rd_en in cycle N+1 gives data_out=0x1234 and rd_valid=1 in cycle N+2.
